// File: rtl/melody_sequencer.sv
// -----------------------------------------------------------------------------
// melody_sequencer
//   Plays a programmable melody for the sine/DAC tone path. A writable table
//   holds {pitch code, duration} pairs; durations count fs sample ticks. For
//   each note the block drives the sine clock-generator divider (tone_maxval)
//   and a tone enable, then inserts a silent articulation gap before the next
//   note. Playback can be started, stopped and looped from the top level.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   sample_tick  one-cycle strobe at fs
//   wr_en        table write strobe
//   wr_addr      table write address
//   wr_pitch     pitch code: 0=A 1=Dhigh 2=C 3=B 4=G 5=Fis 6=E 7=D, 8-15=rest
//   wr_dur       note duration in ticks (0 plays as 1)
//   last_idx     index of last note, sampled at start and at every wrap
//   start        pulse, begins playback at index 0 when idle
//   stop         pulse, aborts playback (beats start)
//   loop         level, wrap to index 0 after the last note instead of ending
//   busy         high while loading, playing or in a gap
//   tone_en      high while playing a non-rest note
//   tone_maxval  divider value for the current pitch, 0 for a rest
//   note_idx     index of the current note
//   done         one-cycle pulse when a non-looping melody completes
// -----------------------------------------------------------------------------
module melody_sequencer #(
    parameter int AW    = 5,
    parameter int DUR_W = 13,
    parameter int DIV_W = 5,
    parameter int GAP   = 80
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_tick,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [3:0]       wr_pitch,
    input  logic [DUR_W-1:0] wr_dur,
    input  logic [AW-1:0]    last_idx,
    input  logic             start,
    input  logic             stop,
    input  logic             loop,
    output logic             busy,
    output logic             tone_en,
    output logic [DIV_W-1:0] tone_maxval,
    output logic [AW-1:0]    note_idx,
    output logic             done
);

    localparam int DEPTH      = 2 ** AW;
    localparam int GAP_LAST_I = (GAP > 0) ? GAP - 1 : 0;
    localparam logic [DUR_W-1:0] GAP_LAST = DUR_W'(GAP_LAST_I);
    localparam logic [DUR_W-1:0] DUR_ONE  = {{(DUR_W-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]    IDX_ONE  = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    // Divider value that makes the sine clkgen produce the requested pitch.
    function automatic logic [DIV_W-1:0] pitch_to_div(input logic [3:0] pitch);
        logic [4:0] div;
        case (pitch)
            4'd0:    div = 5'd18;
            4'd1:    div = 5'd13;
            4'd2:    div = 5'd15;
            4'd3:    div = 5'd16;
            4'd4:    div = 5'd20;
            4'd5:    div = 5'd21;
            4'd6:    div = 5'd24;
            4'd7:    div = 5'd27;
            default: div = 5'd0;
        endcase
        return DIV_W'(div);
    endfunction

    logic [DUR_W+3:0] table_r [DEPTH];

    state_t           state_r,   state_s;
    logic [AW-1:0]    idx_r,     idx_s;
    logic [AW-1:0]    last_r,    last_s;
    logic [DUR_W-1:0] dur_r,     dur_s;
    logic [DUR_W-1:0] cnt_r,     cnt_s;
    logic             busy_r,    busy_s;
    logic             tone_en_r, tone_en_s;
    logic [DIV_W-1:0] maxval_r,  maxval_s;
    logic             done_r,    done_s;

    logic [DUR_W+3:0] rd_entry_s;
    logic [3:0]       rd_pitch_s;
    logic [DUR_W-1:0] rd_dur_s;
    logic [DUR_W-1:0] dur_last_s;
    logic             adv_s;

    // Table read is combinational from the registered index, so a write to the
    // same address on the LOAD edge is seen only by the next read.
    assign rd_entry_s = table_r[idx_r];
    assign rd_pitch_s = rd_entry_s[DUR_W+3:DUR_W];
    assign rd_dur_s   = rd_entry_s[DUR_W-1:0];

    // Note table storage; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            table_r[wr_addr] <= {wr_pitch, wr_dur};
        end
    end

    // Next-state, counter and output decode for the sequencer FSM.
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        last_s    = last_r;
        dur_s     = dur_r;
        cnt_s     = cnt_r;
        tone_en_s = tone_en_r;
        maxval_s  = maxval_r;
        done_s    = 1'b0;
        adv_s     = 1'b0;

        // A zero duration plays as a single tick.
        if (dur_r == {DUR_W{1'b0}}) begin
            dur_last_s = {DUR_W{1'b0}};
        end else begin
            dur_last_s = dur_r - DUR_ONE;
        end

        if (stop) begin
            state_s   = ST_IDLE;
            idx_s     = {AW{1'b0}};
            cnt_s     = {DUR_W{1'b0}};
            tone_en_s = 1'b0;
            maxval_s  = {DIV_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    tone_en_s = 1'b0;
                    maxval_s  = {DIV_W{1'b0}};
                    idx_s     = {AW{1'b0}};
                    if (start) begin
                        state_s = ST_LOAD;
                        last_s  = last_idx;
                        cnt_s   = {DUR_W{1'b0}};
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    dur_s     = rd_dur_s;
                    maxval_s  = pitch_to_div(rd_pitch_s);
                    tone_en_s = ~rd_pitch_s[3];
                    cnt_s     = {DUR_W{1'b0}};
                    state_s   = ST_PLAY;
                end
                ST_PLAY: begin
                    if (sample_tick) begin
                        if (cnt_r == dur_last_s) begin
                            tone_en_s = 1'b0;
                            cnt_s     = {DUR_W{1'b0}};
                            if (GAP > 0) begin
                                state_s = ST_GAP;
                            end else begin
                                adv_s = 1'b1;
                            end
                        end else begin
                            cnt_s = cnt_r + DUR_ONE;
                        end
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                ST_GAP: begin
                    tone_en_s = 1'b0;
                    if (sample_tick) begin
                        if (cnt_r == GAP_LAST) begin
                            cnt_s = {DUR_W{1'b0}};
                            adv_s = 1'b1;
                        end else begin
                            cnt_s = cnt_r + DUR_ONE;
                        end
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase

            // End of a note (after its gap): next note, wrap, or finish.
            if (adv_s) begin
                if (idx_r < last_r) begin
                    idx_s   = idx_r + IDX_ONE;
                    state_s = ST_LOAD;
                end else if (loop) begin
                    idx_s   = {AW{1'b0}};
                    last_s  = last_idx;
                    state_s = ST_LOAD;
                end else begin
                    idx_s    = {AW{1'b0}};
                    maxval_s = {DIV_W{1'b0}};
                    done_s   = 1'b1;
                    state_s  = ST_IDLE;
                end
            end else begin
                done_s = 1'b0;
            end
        end

        busy_s = (state_s != ST_IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            idx_r     <= {AW{1'b0}};
            last_r    <= {AW{1'b0}};
            dur_r     <= {DUR_W{1'b0}};
            cnt_r     <= {DUR_W{1'b0}};
            busy_r    <= 1'b0;
            tone_en_r <= 1'b0;
            maxval_r  <= {DIV_W{1'b0}};
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            last_r    <= last_s;
            dur_r     <= dur_s;
            cnt_r     <= cnt_s;
            busy_r    <= busy_s;
            tone_en_r <= tone_en_s;
            maxval_r  <= maxval_s;
            done_r    <= done_s;
        end
    end

    assign busy        = busy_r;
    assign tone_en     = tone_en_r;
    assign tone_maxval = maxval_r;
    assign note_idx    = idx_r;
    assign done        = done_r;

endmodule

// File: tb/tb_melody_sequencer.sv
// -----------------------------------------------------------------------------
// tb_melody_sequencer
//   Directed bench for melody_sequencer. A phase/countdown model of the
//   playback rules predicts the outputs and is compared every cycle; literal
//   tick counts and latency values pin the model for each scenario.
// -----------------------------------------------------------------------------
module tb_melody_sequencer;

    localparam int AW    = 5;
    localparam int DUR_W = 13;
    localparam int DIV_W = 5;
    localparam int GAP   = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             sample_tick;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [3:0]       wr_pitch;
    logic [DUR_W-1:0] wr_dur;
    logic [AW-1:0]    last_idx;
    logic             start;
    logic             stop;
    logic             loop;
    logic             busy;
    logic             tone_en;
    logic [DIV_W-1:0] tone_maxval;
    logic [AW-1:0]    note_idx;
    logic             done;

    int checks = 0;
    int errors = 0;
    int tick_ph = 0;

    int tab_p [32] = '{default: 0};
    int tab_d [32] = '{default: 0};
    int div_tab [8] = '{18, 13, 15, 16, 20, 21, 24, 27};

    int on_cnt [32] = '{default: 0};
    int gap_cnt  = 0;
    int done_cnt = 0;
    int rest_cnt = 0;

    // phase: 0 idle, 1 load, 2 play, 3 gap; rem counts ticks still to go
    typedef struct packed {
        int phase;
        int rem;
        int idx;
        int last;
        int busy;
        int tone_en;
        int maxval;
        int done;
    } mdl_t;

    mdl_t m;

    melody_sequencer #(.AW(AW), .DUR_W(DUR_W), .DIV_W(DIV_W), .GAP(GAP)) dut (
        .clk(clk), .reset(reset), .sample_tick(sample_tick), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_pitch(wr_pitch), .wr_dur(wr_dur),
        .last_idx(last_idx), .start(start), .stop(stop), .loop(loop),
        .busy(busy), .tone_en(tone_en), .tone_maxval(tone_maxval),
        .note_idx(note_idx), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic mdl_t step(input mdl_t c);
        mdl_t n;
        int   p;
        int   d;
        bit   adv;
        n      = c;
        n.done = 0;
        adv    = 0;
        if (stop) begin
            n = '0;
        end else begin
            case (c.phase)
                0: begin
                    n.tone_en = 0;
                    n.maxval  = 0;
                    n.idx     = 0;
                    if (start) begin
                        n.phase = 1;
                        n.last  = int'(last_idx);
                    end
                end
                1: begin
                    p         = tab_p[c.idx];
                    d         = tab_d[c.idx];
                    n.rem     = (d == 0) ? 1 : d;
                    n.maxval  = (p < 8) ? div_tab[p] : 0;
                    n.tone_en = (p < 8) ? 1 : 0;
                    n.phase   = 2;
                end
                2: begin
                    if (sample_tick) begin
                        n.rem = c.rem - 1;
                        if (n.rem == 0) begin
                            n.tone_en = 0;
                            if (GAP > 0) begin
                                n.phase = 3;
                                n.rem   = GAP;
                            end else begin
                                adv = 1;
                            end
                        end
                    end
                end
                default: begin
                    if (sample_tick) begin
                        n.rem = c.rem - 1;
                        if (n.rem == 0) adv = 1;
                    end
                end
            endcase
            if (adv) begin
                if (c.idx < c.last) begin
                    n.idx   = c.idx + 1;
                    n.phase = 1;
                end else if (loop) begin
                    n.idx   = 0;
                    n.last  = int'(last_idx);
                    n.phase = 1;
                end else begin
                    n.done   = 1;
                    n.phase  = 0;
                    n.idx    = 0;
                    n.maxval = 0;
                end
            end
        end
        n.busy = (n.phase != 0) ? 1 : 0;
        return n;
    endfunction

    always @(posedge clk) begin
        if (wr_en) begin
            tab_p[wr_addr] <= int'(wr_pitch);
            tab_d[wr_addr] <= int'(wr_dur);
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) m <= '0;
        else       m <= step(m);
    end

    // tick/pulse tallies of what the DUT showed just before each edge
    always @(posedge clk) begin
        if (!reset) begin
            if (sample_tick && tone_en) on_cnt[tone_maxval] <= on_cnt[tone_maxval] + 1;
            if (sample_tick && busy && !tone_en) gap_cnt <= gap_cnt + 1;
            if (sample_tick && busy && !tone_en && note_idx == 5'd1 && tone_maxval == 5'd0)
                rest_cnt <= rest_cnt + 1;
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("busy", int'(busy), m.busy);
            check("tone_en", int'(tone_en), m.tone_en);
            check("done", int'(done), m.done);
            if (m.busy != 0) begin
                check("tone_maxval", int'(tone_maxval), m.maxval);
                check("note_idx", int'(note_idx), m.idx);
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        start       = 1'b0;
        stop        = 1'b0;
        wr_en       = 1'b0;
        tick_ph     = (tick_ph == 3) ? 0 : tick_ph + 1;
        sample_tick = (tick_ph == 0);
    endtask

    task automatic wr(input int a, input int p, input int d);
        wr_addr  = AW'(a);
        wr_pitch = 4'(p);
        wr_dur   = DUR_W'(d);
        wr_en    = 1'b1;
        cyc();
    endtask

    // start is sampled on a tick edge so no tick ever lands on a LOAD cycle
    task automatic start_aligned();
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (sample_tick) break;
        end
        start = 1'b1;
        cyc();
    endtask

    task automatic wait_done(input int budget, input string name);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            cyc();
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_idx(input int v, input int budget, input string name);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            cyc();
            if (busy && int'(note_idx) == v) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check({name, "_timeout"}, 0, 1);
    endtask

    int b13, b15, b18, b20, b27, bg, bd, br;

    initial begin
        reset = 1'b1; sample_tick = 1'b0; wr_en = 1'b0; wr_addr = '0;
        wr_pitch = 4'd0; wr_dur = '0; last_idx = '0;
        start = 1'b0; stop = 1'b0; loop = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_tone_en", int'(tone_en), 0);
        check("rst_maxval", int'(tone_maxval), 0);
        check("rst_idx", int'(note_idx), 0);
        check("rst_done", int'(done), 0);
        reset = 1'b0;

        wr(0, 0, 4); wr(1, 4, 2); wr(2, 7, 3);

        // 1: plain three-note melody; last_idx change after start is ignored
        last_idx = 5'd2; loop = 1'b0;
        b18 = on_cnt[18]; b20 = on_cnt[20]; b27 = on_cnt[27]; bg = gap_cnt; bd = done_cnt;
        start_aligned();
        last_idx = 5'd0;
        check("lat_busy", int'(busy), 1);
        check("lat_load_tone_en", int'(tone_en), 0);
        cyc();
        check("lat_tone_en", int'(tone_en), 1);
        check("lat_maxval", int'(tone_maxval), 18);
        wait_done(300, "t1");
        cyc();
        check("t1_idle", int'(busy), 0);
        check("t1_A_ticks", on_cnt[18] - b18, 4);
        check("t1_G_ticks", on_cnt[20] - b20, 2);
        check("t1_D_ticks", on_cnt[27] - b27, 3);
        check("t1_gap_ticks", gap_cnt - bg, 6);
        check("t1_done_once", done_cnt - bd, 1);

        // 2: looping wraps without done; dropping loop finishes the pass
        last_idx = 5'd2; loop = 1'b1; bd = done_cnt;
        start_aligned();
        wait_idx(2, 300, "t2_idx2");
        wait_idx(0, 300, "t2_wrap");
        check("t2_no_done", done_cnt - bd, 0);
        wait_idx(1, 300, "t2_idx1");
        loop = 1'b0;
        wait_done(300, "t2");
        cyc();
        check("t2_done_once", done_cnt - bd, 1);
        check("t2_idle", int'(busy), 0);

        // 3: rest entry keeps silence for its full length
        wr(1, 15, 5);
        bd = done_cnt; br = rest_cnt; b27 = on_cnt[27];
        start_aligned();
        wait_idx(1, 300, "t3_idx1");
        cyc();
        check("t3_rest_tone_en", int'(tone_en), 0);
        check("t3_rest_maxval", int'(tone_maxval), 0);
        wait_idx(2, 300, "t3_idx2");
        wait_done(300, "t3");
        cyc();
        check("t3_rest_ticks", rest_cnt - br, 7);
        check("t3_D_ticks", on_cnt[27] - b27, 3);
        check("t3_done_once", done_cnt - bd, 1);

        // 4: stop mid-note, then restart from index 0
        wr(1, 4, 2);
        bd = done_cnt;
        start_aligned();
        wait_idx(1, 300, "t4_idx1");
        cyc();
        stop = 1'b1;
        cyc();
        check("t4_busy", int'(busy), 0);
        check("t4_tone_en", int'(tone_en), 0);
        check("t4_maxval", int'(tone_maxval), 0);
        check("t4_idx", int'(note_idx), 0);
        repeat (3) cyc();
        check("t4_no_done", done_cnt - bd, 0);
        start_aligned();
        cyc();
        check("t4_re_idx", int'(note_idx), 0);
        check("t4_re_maxval", int'(tone_maxval), 18);
        wait_done(300, "t4");
        cyc();

        // 5: asynchronous reset mid-note
        start_aligned();
        cyc();
        #2 reset = 1'b1;
        #1;
        check("t5_busy", int'(busy), 0);
        check("t5_tone_en", int'(tone_en), 0);
        check("t5_maxval", int'(tone_maxval), 0);
        check("t5_idx", int'(note_idx), 0);
        check("t5_done", int'(done), 0);
        cyc(); cyc();
        reset = 1'b0;
        repeat (5) cyc();
        check("t5_stays_idle", int'(busy), 0);

        // 6a: start and stop together
        start = 1'b1; stop = 1'b1;
        cyc();
        check("t6_ss_busy", int'(busy), 0);
        cyc();
        check("t6_ss_busy2", int'(busy), 0);

        // 6b: rewrite idx 2 while idx 0 plays
        last_idx = 5'd2;
        b15 = on_cnt[15]; b27 = on_cnt[27];
        start_aligned();
        cyc();
        wr(2, 2, 3);
        wait_done(300, "t6b");
        cyc();
        check("t6_new_C_ticks", on_cnt[15] - b15, 3);
        check("t6_old_D_ticks", on_cnt[27] - b27, 0);

        // 6c: zero duration plays one tick
        wr(0, 1, 0);
        last_idx = 5'd0;
        b13 = on_cnt[13];
        start_aligned();
        wait_done(300, "t6c");
        cyc();
        check("t6_dur0_ticks", on_cnt[13] - b13, 1);
        check("t6_dur0_idle", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
